// File: rtl/digit_serial_multiplier_if.sv
// Request/result bundle between a controller and digit_serial_multiplier.
// The controller drives start/a/b and receives busy/done/product.
interface digit_serial_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/digit_serial_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier built around one shared 2x2-bit multiplier.
// Latency: done in the cycle after (WIDTH/2)^2 partial-product edges; period (WIDTH/2)^2+2.
// Backpressure: start is only sampled in IDLE; busy/done tell the controller when to retry.

module two_bit_multiplier (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    assign p = {2'b00, x} * {2'b00, y};
endmodule

module digit_serial_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    digit_serial_multiplier_if.slave  bus
);
    localparam int D  = WIDTH / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int AW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    product_r;
    logic [IW-1:0]    i;
    logic [IW-1:0]    j;
    logic             busy_r;
    logic             done_r;

    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic [3:0]       pp;
    logic [AW-1:0]    pp_ext;
    logic [IW+1:0]    sh;
    logic [AW-1:0]    acc_sum;
    logic             last_step;

    // Digit pair selection: i walks a's digits, j walks b's digits.
    assign a_dig = a_reg[{i, 1'b0} +: 2];
    assign b_dig = b_reg[{j, 1'b0} +: 2];

    two_bit_multiplier u_mul (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    // Weight of digit pair (i,j) is 4^(i+j); the full sum always fits in AW bits.
    assign pp_ext    = AW'(pp);
    assign sh        = {({1'b0, i} + {1'b0, j}), 1'b0};
    assign acc_sum   = acc + (pp_ext << sh);
    assign last_step = (i == LAST) && (j == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            product_r <= '0;
            i         <= '0;
            j         <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_reg  <= bus.a;
                        b_reg  <= bus.b;
                        acc    <= '0;
                        i      <= '0;
                        j      <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (last_step) begin
                        // Product is published only here, so partial sums never leak out.
                        product_r <= acc_sum;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        i         <= '0;
                        j         <= '0;
                        state     <= DONE;
                    end else if (i == LAST) begin
                        i <= '0;
                        j <= j + 1'b1;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Scoreboard bench for digit_serial_multiplier at WIDTH=8 and WIDTH=4.
// Expected products are queued at stimulus time and popped when done pulses.
module tb_digit_serial_multiplier;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    digit_serial_multiplier_if #(.WIDTH(8)) bus8 ();
    digit_serial_multiplier_if #(.WIDTH(4)) bus4 ();

    digit_serial_multiplier #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    digit_serial_multiplier #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    int vectors;
    int miscompares;
    logic [15:0] exp_q8[$];

    // Runs one WIDTH=8 operation: queues the expected product, then waits for done.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expv,
                        output int busy_cycles, output bit got_done, output bit overlap,
                        output logic [15:0] prod);
        busy_cycles = 0;
        got_done    = 1'b0;
        overlap     = 1'b0;
        prod        = '0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = av;
        bus8.b     = bv;
        exp_q8.push_back(expv);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        for (int n = 0; n < 40 && !got_done; n++) begin
            if (bus8.busy && bus8.done) overlap = 1'b1;
            if (bus8.done) begin
                got_done = 1'b1;
                prod     = bus8.product;
            end else begin
                if (bus8.busy) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.product !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_async8: busy=%b done=%b product=%h, want 0 0 0000",
                     bus8.busy, bus8.done, bus8.product);
        end
        vectors++;
        if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.product !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async4: busy=%b done=%b product=%h, want 0 0 00",
                     bus4.busy, bus4.done, bus4.product);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.product !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_hold: busy=%b done=%b product=%h, want 0 0 0000",
                     bus8.busy, bus8.done, bus8.product);
        end
    endtask

    task automatic check_op(input string name, input int busy_cycles, input bit got_done,
                            input bit overlap, input logic [15:0] prod);
        logic [15:0] expv;
        vectors++;
        if (!got_done) begin
            miscompares++;
            $display("FAIL %s_done: no done within budget, want done pulse", name);
        end
        vectors++;
        if (busy_cycles != 16) begin
            miscompares++;
            $display("FAIL %s_latency: busy cycles=%0d, want 16", name, busy_cycles);
        end
        vectors++;
        if (overlap) begin
            miscompares++;
            $display("FAIL %s_overlap: busy and done high together, want never", name);
        end
        expv = (exp_q8.size() > 0) ? exp_q8.pop_front() : 16'hxxxx;
        vectors++;
        if (prod !== expv) begin
            miscompares++;
            $display("FAIL %s_product: got %h, want %h", name, prod, expv);
        end
    endtask

    task automatic test_ff_times_ff;
        int bc; bit gd; bit ov; logic [15:0] pr;
        run8(8'hFF, 8'hFF, 16'hFE01, bc, gd, ov, pr);
        check_op("ffxff", bc, gd, ov, pr);
        @(negedge clk);
        vectors++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ffxff_pulse_width: done=%b busy=%b, want 0 0", bus8.done, bus8.busy);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (bus8.product !== 16'hFE01 || bus8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL ffxff_hold: product=%h done=%b, want fe01 0", bus8.product, bus8.done);
        end
    endtask

    task automatic test_zero_then_small;
        int bc; bit gd; bit ov; logic [15:0] pr;
        run8(8'h00, 8'hA7, 16'h0000, bc, gd, ov, pr);
        check_op("zero", bc, gd, ov, pr);
        run8(8'h12, 8'h34, 16'h03A8, bc, gd, ov, pr);
        check_op("small", bc, gd, ov, pr);
    endtask

    task automatic test_interference;
        int dones;
        logic [15:0] prod;
        logic [15:0] expv;
        dones = 0;
        prod  = '0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h0F;
        bus8.b     = 8'h10;
        exp_q8.push_back(16'h00F0);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
        for (int n = 0; n < 30; n++) begin
            bus8.start = (n >= 1 && n <= 10);
            if (bus8.done) begin
                dones++;
                prod = bus8.product;
            end
            @(negedge clk);
        end
        bus8.start = 1'b0;
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL interfere_pulses: done pulses=%0d, want 1", dones);
        end
        expv = (exp_q8.size() > 0) ? exp_q8.pop_front() : 16'hxxxx;
        vectors++;
        if (prod !== expv) begin
            miscompares++;
            $display("FAIL interfere_product: got %h, want %h", prod, expv);
        end
    endtask

    task automatic test_reset_midop;
        int dones;
        int bc; bit gd; bit ov; logic [15:0] pr;
        dones = 0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'hC8;
        bus8.b     = 8'h64;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.product !== 16'h0000) begin
            miscompares++;
            $display("FAIL midop_reset: busy=%b done=%b product=%h, want 0 0 0000",
                     bus8.busy, bus8.done, bus8.product);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus8.done || bus8.busy) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL midop_discard: busy/done cycles after reset=%0d, want 0", dones);
        end
        run8(8'h03, 8'h05, 16'h000F, bc, gd, ov, pr);
        check_op("after_reset", bc, gd, ov, pr);
    endtask

    task automatic test_width4_back_to_back;
        int busy_cycles;
        int pulses;
        int last_idx;
        int bad_gap;
        int bad_prod;
        bit got_done;
        busy_cycles = 0;
        got_done    = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = 4'hB;
        bus4.b     = 4'hD;
        @(negedge clk);
        bus4.start = 1'b0;
        for (int n = 0; n < 20 && !got_done; n++) begin
            if (bus4.done) got_done = 1'b1;
            else begin
                if (bus4.busy) busy_cycles++;
                @(negedge clk);
            end
        end
        vectors++;
        if (!got_done || busy_cycles != 4) begin
            miscompares++;
            $display("FAIL w4_latency: done=%b busy cycles=%0d, want 1 4", got_done, busy_cycles);
        end
        vectors++;
        if (bus4.product !== 8'h8F) begin
            miscompares++;
            $display("FAIL w4_product: got %h, want 8f", bus4.product);
        end
        pulses   = 0;
        last_idx = -1;
        bad_gap  = 0;
        bad_prod = 0;
        @(negedge clk);
        bus4.start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (bus4.done) begin
                if (last_idx >= 0 && n - last_idx != 6) bad_gap++;
                if (bus4.product !== 8'h8F) bad_prod++;
                last_idx = n;
                pulses++;
            end
            @(negedge clk);
        end
        bus4.start = 1'b0;
        vectors++;
        if (pulses < 6 || bad_gap != 0) begin
            miscompares++;
            $display("FAIL w4_period: pulses=%0d bad gaps=%0d, want >=6 pulses every 6 cycles",
                     pulses, bad_gap);
        end
        vectors++;
        if (bad_prod != 0) begin
            miscompares++;
            $display("FAIL w4_b2b_product: %0d pulses with wrong product, want 0", bad_prod);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus8.start  = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        bus4.start  = 1'b0;
        bus4.a      = '0;
        bus4.b      = '0;
        test_reset();
        test_ff_times_ff();
        test_zero_then_small();
        test_interference();
        test_reset_midop();
        test_width4_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
